// File: rtl/rs_wakeup_issue.sv
// rs_wakeup_issue: reservation station that buffers dispatched operations, wakes waiting
// source operands from the common data bus and issues one ready entry per cycle through a
// registered valid/ready port.
// Optional build macro OLDEST_FIRST_EN: select the oldest ready entry using an age matrix.
// When it is undefined, the lowest-index ready entry is selected.
module rs_wakeup_issue #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned OP_W    = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned RS_ID   = 1,
  parameter int unsigned ID_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_op,
  input  logic [TAG_W-1:0]          in_dst_tag,
  input  logic [NUM_SRC*TAG_W-1:0]  in_src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] in_src_val,
  input  logic [NUM_SRC-1:0]        in_src_rdy,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_op,
  output logic [TAG_W-1:0]          out_dst_tag,
  output logic [NUM_SRC*DATA_W-1:0] out_src_val,
  output logic [ID_W-1:0]           out_entry_id,
  output logic [$clog2(DEPTH):0]    free_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [ID_W-1:0] ID_BASE = ID_W'(RS_ID << IDX_W);

  // Entry storage
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [OP_W-1:0]    op_q  [DEPTH];
  logic [OP_W-1:0]    op_d  [DEPTH];
  logic [TAG_W-1:0]   dst_q [DEPTH];
  logic [TAG_W-1:0]   dst_d [DEPTH];
  logic [TAG_W-1:0]   tag_q [DEPTH][NUM_SRC];
  logic [TAG_W-1:0]   tag_d [DEPTH][NUM_SRC];
  logic [DATA_W-1:0]  val_q [DEPTH][NUM_SRC];
  logic [DATA_W-1:0]  val_d [DEPTH][NUM_SRC];
  logic [NUM_SRC-1:0] rdy_q [DEPTH];
  logic [NUM_SRC-1:0] rdy_d [DEPTH];

  logic [DEPTH-1:0]          ready;
  logic                      alloc;
  logic [IDX_W-1:0]          alloc_idx;
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic                      issue_load;
  logic                      issue_fire;
  logic [NUM_SRC*DATA_W-1:0] sel_val;

  assign in_ready   = ~&busy_q;
  assign alloc      = in_valid && in_ready && !flush;
  assign issue_load = !out_valid || out_ready;
  assign issue_fire = issue_load && sel_found && !flush;

  // Ready vector and free-entry count, both from registered state only
  always_comb begin
    ready      = '0;
    free_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i]   = busy_q[i] & (&rdy_q[i]);
      free_count = free_count + {{IDX_W{1'b0}}, ~busy_q[i]};
    end
  end

  // Lowest-index free slot (descending scan leaves the lowest match last)
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

`ifdef OLDEST_FIRST_EN
  // older_q[i][j] set means entry j was allocated before entry i and is still live
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] free_mask;

  assign free_mask = issue_fire ? (DEPTH'(1) << sel_idx) : '0;

  // Select the ready entry with no older ready entry; the age order is total, so it is unique
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && ((older_q[i] & ready) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Age matrix update: forget freed entries, record survivors as older than a new entry
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_d[i] & ~free_mask;
    end
    if (alloc) older_d[alloc_idx] = busy_q & ~free_mask;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end
  end

  // Age matrix register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end
`else
  // Fixed priority: lowest-index ready entry
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Gather the selected entry's operands into the packed issue layout
  always_comb begin
    sel_val = '0;
    for (int s = 0; s < NUM_SRC; s++) sel_val[s*DATA_W +: DATA_W] = val_q[sel_idx][s];
  end

  // Entry next state: CDB wakeup, issue free, allocation with bypass, flush last (priority)
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    dst_d  = dst_q;
    tag_d  = tag_q;
    val_d  = val_q;
    rdy_d  = rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (busy_q[i] && !rdy_q[i][s]) begin
          // Descending scan so the lowest matching channel wins
          for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag_q[i][s]) begin
              val_d[i][s] = cdb_data[c*DATA_W +: DATA_W];
              rdy_d[i][s] = 1'b1;
            end
          end
        end
      end
    end
    if (issue_fire) busy_d[sel_idx] = 1'b0;
    if (alloc) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = in_op;
      dst_d[alloc_idx]  = in_dst_tag;
      for (int s = 0; s < NUM_SRC; s++) begin
        tag_d[alloc_idx][s] = in_src_tag[s*TAG_W +: TAG_W];
        val_d[alloc_idx][s] = in_src_val[s*DATA_W +: DATA_W];
        rdy_d[alloc_idx][s] = in_src_rdy[s];
        if (!in_src_rdy[s]) begin
          for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == in_src_tag[s*TAG_W +: TAG_W]) begin
              val_d[alloc_idx][s] = cdb_data[c*DATA_W +: DATA_W];
              rdy_d[alloc_idx][s] = 1'b1;
            end
          end
        end
      end
    end
    if (flush) busy_d = '0;
  end

  // Entry state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        dst_q[i] <= '0;
        rdy_q[i] <= '0;
        for (int s = 0; s < NUM_SRC; s++) begin
          tag_q[i][s] <= '0;
          val_q[i][s] <= '0;
        end
      end
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      dst_q  <= dst_d;
      tag_q  <= tag_d;
      val_q  <= val_d;
      rdy_q  <= rdy_d;
    end
  end

  // Issue register: loads when empty or being drained, holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_op       <= '0;
      out_dst_tag  <= '0;
      out_src_val  <= '0;
      out_entry_id <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue_load) begin
      out_valid <= sel_found;
      if (sel_found) begin
        out_op       <= op_q[sel_idx];
        out_dst_tag  <= dst_q[sel_idx];
        out_src_val  <= sel_val;
        out_entry_id <= ID_BASE | ID_W'(sel_idx);
      end
    end
  end

endmodule

// File: tb/tb_rs_wakeup_issue.sv
// tb_rs_wakeup_issue: directed and randomized checks of rs_wakeup_issue against a
// slot-level behavioural model (default parameters: DEPTH=8, NUM_SRC=2, NUM_CDB=2, RS_ID=1).
module tb_rs_wakeup_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_op = '0;
  logic [5:0]  in_dst_tag = '0;
  logic [11:0] in_src_tag = '0;
  logic [63:0] in_src_val = '0;
  logic [1:0]  in_src_rdy = '0;
  logic [1:0]  cdb_valid = '0;
  logic [11:0] cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_op;
  logic [5:0]  out_dst_tag;
  logic [63:0] out_src_val;
  logic [7:0]  out_entry_id;
  logic [3:0]  free_count;

  rs_wakeup_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dst_tag(in_dst_tag),
    .in_src_tag(in_src_tag), .in_src_val(in_src_val), .in_src_rdy(in_src_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_dst_tag(out_dst_tag),
    .out_src_val(out_src_val), .out_entry_id(out_entry_id), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one record per slot plus the issue register
  bit          m_busy [8];
  logic [7:0]  m_op   [8];
  logic [5:0]  m_dst  [8];
  logic [5:0]  m_tag  [8][2];
  logic [31:0] m_val  [8][2];
  bit          m_rdy  [8][2];
  int unsigned m_seq  [8];
  int unsigned seq_ctr = 0;
  bit          mo_valid = 1'b0;
  logic [7:0]  mo_op = '0;
  logic [5:0]  mo_dst = '0;
  logic [63:0] mo_val = '0;
  logic [7:0]  mo_id = '0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // First valid CDB channel (lowest index) carrying tag t
  function automatic bit cdb_lookup(input logic [5:0] t, output logic [31:0] d);
    bit hit = 1'b0;
    d = '0;
    for (int c = 0; c < 2; c++) begin
      if (!hit && cdb_valid[c] && cdb_tag[c*6 +: 6] == t) begin
        hit = 1'b1;
        d   = cdb_data[c*32 +: 32];
      end
    end
    return hit;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int pick = -1;
    int slot = -1;
    bit hit;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i] && m_rdy[i][0] && m_rdy[i][1]) begin
`ifdef OLDEST_FIRST_EN
        if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
      if (!m_busy[i] && slot < 0) slot = i;
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      mo_valid = 1'b0;
      return;
    end
    if (!mo_valid || out_ready) begin
      mo_valid = (pick >= 0);
      if (pick >= 0) begin
        mo_op  = m_op[pick];
        mo_dst = m_dst[pick];
        mo_val = {m_val[pick][1], m_val[pick][0]};
        mo_id  = 8'(8 + pick);
        m_busy[pick] = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 2; s++) begin
        hit = cdb_lookup(m_tag[i][s], d);
        if (m_busy[i] && !m_rdy[i][s] && hit) begin
          m_val[i][s] = d;
          m_rdy[i][s] = 1'b1;
        end
      end
    end
    if (in_valid && slot >= 0) begin
      m_busy[slot] = 1'b1;
      m_op[slot]   = in_op;
      m_dst[slot]  = in_dst_tag;
      m_seq[slot]  = seq_ctr;
      seq_ctr++;
      for (int s = 0; s < 2; s++) begin
        m_tag[slot][s] = in_src_tag[s*6 +: 6];
        m_val[slot][s] = in_src_val[s*32 +: 32];
        m_rdy[slot][s] = in_src_rdy[s];
        hit = cdb_lookup(m_tag[slot][s], d);
        if (!in_src_rdy[s] && hit) begin
          m_val[slot][s] = d;
          m_rdy[slot][s] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle_check();
    int nfree = 0;
    for (int i = 0; i < 8; i++) if (!m_busy[i]) nfree++;
    chk("out_valid", 64'(out_valid), 64'(mo_valid));
    chk("in_ready", 64'(in_ready), 64'(nfree > 0));
    chk("free_count", 64'(free_count), 64'(nfree));
    if (mo_valid) begin
      chk("out_op", 64'(out_op), 64'(mo_op));
      chk("out_dst_tag", 64'(out_dst_tag), 64'(mo_dst));
      chk("out_src_val", out_src_val, mo_val);
      chk("out_entry_id", 64'(out_entry_id), 64'(mo_id));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cycle_check();
  endtask

  task automatic disp(input logic [7:0] op, input logic [5:0] dst,
                      input logic [5:0] t0, input bit r0, input logic [31:0] v0,
                      input logic [5:0] t1, input bit r1, input logic [31:0] v1);
    in_valid   = 1'b1;
    in_op      = op;
    in_dst_tag = dst;
    in_src_tag = {t1, t0};
    in_src_val = {v1, v0};
    in_src_rdy = {r1, r0};
  endtask

  task automatic cdb(input bit v0, input logic [5:0] t0, input logic [31:0] d0,
                     input bit v1, input logic [5:0] t1, input logic [31:0] d1);
    cdb_valid = {v1, v0};
    cdb_tag   = {t1, t0};
    cdb_data  = {d1, d0};
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_dst", 64'(out_dst_tag), 64'd0);
    chk("rst_out_val", out_src_val, 64'd0);
    chk("rst_out_id", 64'(out_entry_id), 64'd0);
    chk("rst_free", 64'(free_count), 64'd8);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Ready-at-dispatch operation issues one cycle after allocation
    out_ready = 1'b1;
    disp(8'h11, 6'd5, 6'd1, 1'b1, 32'hA, 6'd2, 1'b1, 32'hB);
    tick();
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    idle();
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_op", 64'(out_op), 64'h11);
    chk("t1_val", out_src_val, {32'hB, 32'hA});
    chk("t1_id", 64'(out_entry_id), 64'h08);
    chk("t1_free", 64'(free_count), 64'd8);

    // CDB wakeup on channel 1; issue follows the broadcast by one cycle
    disp(8'h22, 6'd9, 6'd3, 1'b0, 32'h0, 6'd4, 1'b1, 32'h44);
    tick();
    idle();
    tick();
    cdb(1'b0, 6'd0, 32'h0, 1'b1, 6'd3, 32'hDEAD);
    tick();
    chk("t2_same_cycle", 64'(out_valid), 64'd0);
    idle();
    tick();
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_val", out_src_val, {32'h44, 32'hDEAD});

    // Dispatch bypass from a same-cycle broadcast
    disp(8'h33, 6'd10, 6'd7, 1'b0, 32'h0, 6'd8, 1'b1, 32'h88);
    cdb(1'b1, 6'd7, 32'h55, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    tick();
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_val", out_src_val, {32'h88, 32'h55});

    // Fill all slots with waiting operations, then wake slot 4
    for (int i = 0; i < 8; i++) begin
      disp(8'(8'h80 + i), 6'(i), 6'(20 + i), 1'b0, 32'h0, 6'd0, 1'b1, 32'(i));
      tick();
    end
    chk("t4_full_ready", 64'(in_ready), 64'd0);
    chk("t4_full_free", 64'(free_count), 64'd0);
    disp(8'h99, 6'd1, 6'd1, 1'b1, 32'h1, 6'd1, 1'b1, 32'h1);
    tick();
    chk("t4_ignored", 64'(free_count), 64'd0);
    idle();
    cdb(1'b1, 6'd24, 32'h2424, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    tick();
    chk("t4_woken_id", 64'(out_entry_id), 64'h0C);
    chk("t4_woken_op", 64'(out_op), 64'h84);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      cdb(1'b1, 6'(20 + i), 32'(32'h100 + i), 1'b0, 6'd0, 32'h0);
      tick();
    end
    idle();
    repeat (10) tick();

    // Stalled issue port holds its contents and frees nothing
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(8'(8'h40 + i), 6'(i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i + 16));
      tick();
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_hold_op", 64'(out_op), 64'h40);
      chk("t5_hold_free", 64'(free_count), 64'd5);
    end
    out_ready = 1'b1;
    repeat (5) tick();

    // Flush with live entries, a held issue and a same-cycle dispatch
    out_ready = 1'b0;
    disp(8'h60, 6'd1, 6'd0, 1'b1, 32'h6, 6'd0, 1'b1, 32'h60);
    tick();
    for (int i = 0; i < 5; i++) begin
      disp(8'(8'h61 + i), 6'd2, 6'd40, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      tick();
    end
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_free", 64'(free_count), 64'd3);
    disp(8'h70, 6'd3, 6'd0, 1'b1, 32'h7, 6'd0, 1'b1, 32'h70);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_free", 64'(free_count), 64'd8);
    out_ready = 1'b1;
    cdb(1'b1, 6'd40, 32'hBAD, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with small tag space so wakeups and bypasses are frequent
    for (int n = 0; n < 600; n++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_op      = 8'($urandom);
      in_dst_tag = 6'($urandom_range(0, 63));
      in_src_tag = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      in_src_val = {32'($urandom), 32'($urandom)};
      in_src_rdy = 2'($urandom_range(0, 3));
      cdb_valid  = 2'($urandom_range(0, 3));
      cdb_tag    = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      cdb_data   = {32'($urandom), 32'($urandom)};
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
